header_stripper: RTL and testbench

//  Receive-side counterpart of the stream header insertion: removes a fixed-size header from the

---
 rtl/aes_stream_pkg.sv | 14 +
 rtl/header_stripper.sv | 175 +++++++++++++++++
 tb/tb_header_stripper.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_stream_pkg.sv
// rtl/aes_stream_pkg.sv - shared state type and sizing helper for the AES stream datapath
package aes_stream_pkg;

    typedef enum logic [1:0] {
        HDR_ST  = 2'd0,
        DATA_ST = 2'd1,
        DROP_ST = 2'd2
    } hs_state_t;

    function automatic int hdr_beats(input int header_size, input int data_width);
        return header_size / data_width;
    endfunction

endpackage

// File: rtl/header_stripper.sv
// rtl/header_stripper.sv - strips a fixed-size header from each packet and forwards only the payload
// Optional HEADER_STRIPPER_CHECK_EN: compares the header against expected_header and drops mismatching payloads.
module header_stripper
    import aes_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 128,
    parameter int HEADER_SIZE = 256,
    localparam int EMPTY_W    = $clog2(DATA_WIDTH / 8)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  data_in_data,
    input  logic                   data_in_valid,
    input  logic                   data_in_sop,
    input  logic                   data_in_eop,
    input  logic [EMPTY_W-1:0]     data_in_empty,
    output logic                   data_in_ready,
    output logic [DATA_WIDTH-1:0]  data_out_data,
    output logic                   data_out_valid,
    output logic                   data_out_sop,
    output logic                   data_out_eop,
    output logic [EMPTY_W-1:0]     data_out_empty,
    input  logic                   data_out_ready,
    output logic [HEADER_SIZE-1:0] header_data,
    output logic                   header_valid,
`ifdef HEADER_STRIPPER_CHECK_EN
    input  logic [HEADER_SIZE-1:0] expected_header,
    output logic                   hdr_mismatch,
`endif
    output logic                   hdr_short_err
);

    localparam int HDR_BEATS = hdr_beats(HEADER_SIZE, DATA_WIDTH);
    localparam int CNT_W     = $clog2(HDR_BEATS) + 1;

    if ((HEADER_SIZE % DATA_WIDTH) != 0 || HEADER_SIZE < DATA_WIDTH) begin : g_bad_params
        $error("header_stripper: HEADER_SIZE must be a nonzero multiple of DATA_WIDTH");
    end

    hs_state_t              state_q, state_d;
    logic [CNT_W-1:0]       hdr_cnt_q, hdr_cnt_d;
    logic [HEADER_SIZE-1:0] hdr_buf_q, hdr_buf_d;
    logic [HEADER_SIZE-1:0] header_data_q, header_data_d;
    logic                   header_valid_q, header_valid_d;
    logic                   short_err_q, short_err_d;
    logic                   first_pl_q, first_pl_d;

    logic                   in_xfer;
    logic                   hdr_xfer;
    logic                   hdr_done;
    logic                   hdr_short;
    logic                   hdr_bad;
    logic [CNT_W-1:0]       hdr_idx;

    // A sop inside the header restarts capture, so it always lands in beat 0.
    always_comb begin
        in_xfer   = data_in_valid & data_in_ready;
        hdr_xfer  = in_xfer & (state_q == HDR_ST);
        hdr_idx   = data_in_sop ? '0 : hdr_cnt_q;
        hdr_short = hdr_xfer & data_in_eop;
        hdr_done  = hdr_xfer & ~data_in_eop & (hdr_idx == CNT_W'(HDR_BEATS - 1));

        hdr_buf_d = hdr_buf_q;
        if (hdr_xfer) begin
            for (int b = 0; b < HDR_BEATS; b++) begin
                if (hdr_idx == CNT_W'(b)) begin
                    hdr_buf_d[HEADER_SIZE-1-DATA_WIDTH*b -: DATA_WIDTH] = data_in_data;
                end
            end
        end

        hdr_cnt_d = hdr_cnt_q;
        if (hdr_xfer) begin
            hdr_cnt_d = (hdr_short | hdr_done) ? '0 : hdr_idx + CNT_W'(1);
        end

        header_data_d  = hdr_done ? hdr_buf_d : header_data_q;
        header_valid_d = hdr_done;
        short_err_d    = hdr_short;

        first_pl_d = first_pl_q;
        if (hdr_done) begin
            first_pl_d = 1'b1;
        end else if (in_xfer && state_q == DATA_ST) begin
            first_pl_d = 1'b0;
        end

`ifdef HEADER_STRIPPER_CHECK_EN
        hdr_bad = hdr_done & (hdr_buf_d != expected_header);
`else
        hdr_bad = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HDR_ST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR_ST:           if (hdr_done) state_d = hdr_bad ? DROP_ST : DATA_ST;
            DATA_ST, DROP_ST: if (in_xfer && data_in_eop) state_d = HDR_ST;
            default:          state_d = HDR_ST;
        endcase
    end

    always_comb begin
        data_in_ready  = 1'b0;
        data_out_valid = 1'b0;
        data_out_data  = '0;
        data_out_sop   = 1'b0;
        data_out_eop   = 1'b0;
        data_out_empty = '0;
        case (state_q)
            HDR_ST, DROP_ST: data_in_ready = 1'b1;
            DATA_ST: begin
                data_in_ready  = data_out_ready;
                data_out_valid = data_in_valid;
                if (data_in_valid) begin
                    data_out_data  = data_in_data;
                    data_out_sop   = first_pl_q;
                    data_out_eop   = data_in_eop;
                    data_out_empty = data_in_eop ? data_in_empty : '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_cnt_q      <= '0;
            hdr_buf_q      <= '0;
            header_data_q  <= '0;
            header_valid_q <= 1'b0;
            short_err_q    <= 1'b0;
            first_pl_q     <= 1'b0;
        end else begin
            hdr_cnt_q      <= hdr_cnt_d;
            hdr_buf_q      <= hdr_buf_d;
            header_data_q  <= header_data_d;
            header_valid_q <= header_valid_d;
            short_err_q    <= short_err_d;
            first_pl_q     <= first_pl_d;
        end
    end

`ifdef HEADER_STRIPPER_CHECK_EN
    logic mismatch_q, mismatch_d;

    always_comb begin
        mismatch_d = hdr_bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign hdr_mismatch = mismatch_q;
`endif

    assign header_data   = header_data_q;
    assign header_valid  = header_valid_q;
    assign hdr_short_err = short_err_q;

endmodule

// File: tb/tb_header_stripper.sv
// tb/tb_header_stripper.sv - randomized self-checking bench for header_stripper (2-beat and 1-beat header instances)
`timescale 1ns/1ps
module tb_header_stripper;

    typedef struct packed {
        logic [127:0] d;
        logic         sop;
        logic         eop;
        logic [3:0]   empty;
    } beat_t;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic [127:0] in_data   = '0;
    logic         in_sop    = 1'b0;
    logic         in_eop    = 1'b0;
    logic [3:0]   in_empty  = '0;
    logic         in_valid0 = 1'b0;
    logic         in_valid1 = 1'b0;
    logic         out_ready = 1'b1;

    logic         i_ready[2];
    logic         o_valid[2];
    logic         o_sop[2];
    logic         o_eop[2];
    logic         o_hv[2];
    logic         o_se[2];
    logic [127:0] o_data[2];
    logic [3:0]   o_empty[2];
    logic [255:0] hdr_data0;
    logic [127:0] hdr_data1;
    logic [255:0] hdr_w[2];
`ifdef HEADER_STRIPPER_CHECK_EN
    logic [255:0] exp_in0 = '0;
    logic [127:0] exp_in1 = '0;
    logic         o_mm[2];
`endif

    int           n_checks = 0;
    int           n_fail   = 0;
    int           rdy_mode = 0;
    beat_t        obs_q[2][$];
    beat_t        exp_q[2][$];
    int           hv[2], se[2], mm[2], mirror_bad[2], zero_bad[2];
    int           exp_hv[2], exp_se[2], exp_mm[2];
    logic [255:0] hdr_seen[2];
    logic [255:0] exp_hdr[2];
    logic [127:0] pkt[$];

    always #5 clk = ~clk;

    assign hdr_w[0] = hdr_data0;
    assign hdr_w[1] = {128'b0, hdr_data1};

    header_stripper #(.DATA_WIDTH(128), .HEADER_SIZE(256)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .data_in_data(in_data), .data_in_valid(in_valid0), .data_in_sop(in_sop),
        .data_in_eop(in_eop), .data_in_empty(in_empty), .data_in_ready(i_ready[0]),
        .data_out_data(o_data[0]), .data_out_valid(o_valid[0]), .data_out_sop(o_sop[0]),
        .data_out_eop(o_eop[0]), .data_out_empty(o_empty[0]), .data_out_ready(out_ready),
        .header_data(hdr_data0), .header_valid(o_hv[0]),
`ifdef HEADER_STRIPPER_CHECK_EN
        .expected_header(exp_in0), .hdr_mismatch(o_mm[0]),
`endif
        .hdr_short_err(o_se[0])
    );

    header_stripper #(.DATA_WIDTH(128), .HEADER_SIZE(128)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .data_in_data(in_data), .data_in_valid(in_valid1), .data_in_sop(in_sop),
        .data_in_eop(in_eop), .data_in_empty(in_empty), .data_in_ready(i_ready[1]),
        .data_out_data(o_data[1]), .data_out_valid(o_valid[1]), .data_out_sop(o_sop[1]),
        .data_out_eop(o_eop[1]), .data_out_empty(o_empty[1]), .data_out_ready(out_ready),
        .header_data(hdr_data1), .header_valid(o_hv[1]),
`ifdef HEADER_STRIPPER_CHECK_EN
        .expected_header(exp_in1), .hdr_mismatch(o_mm[1]),
`endif
        .hdr_short_err(o_se[1])
    );

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       out_ready = ~out_ready;
            2:       out_ready = 1'($urandom_range(0, 1));
            3:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    // Observe mid-cycle: a beat seen with valid & ready here transfers on the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (o_valid[k] && out_ready) obs_q[k].push_back({o_data[k], o_sop[k], o_eop[k], o_empty[k]});
                if (o_valid[k] && i_ready[k] !== out_ready) mirror_bad[k]++;
                if (!o_valid[k] && {o_data[k], o_sop[k], o_eop[k], o_empty[k]} !== 134'd0) zero_bad[k]++;
                if (o_hv[k]) begin
                    hv[k]++;
                    hdr_seen[k] = hdr_w[k];
                end
                if (o_se[k]) se[k]++;
`ifdef HEADER_STRIPPER_CHECK_EN
                if (o_mm[k]) mm[k]++;
`endif
            end
        end
    end

    task automatic clear_all();
        for (int k = 0; k < 2; k++) begin
            obs_q[k].delete();
            exp_q[k].delete();
            hv[k] = 0; se[k] = 0; mm[k] = 0; mirror_bad[k] = 0; zero_bad[k] = 0;
            exp_hv[k] = 0; exp_se[k] = 0; exp_mm[k] = 0;
        end
    endtask

    // Reference: first hb beats form the header (beat 0 most significant), the rest is payload.
    task automatic model_pkt(input int s, input logic [3:0] emp, input bit force_match);
        int           hb;
        logic [255:0] h;
        hb = (s == 0) ? 2 : 1;
        h  = '0;
        if (pkt.size() <= hb) begin
            exp_se[s]++;
            return;
        end
        for (int i = 0; i < hb; i++) h = (h << 128) | {128'b0, pkt[i]};
        exp_hv[s]++;
        exp_hdr[s] = h;
`ifdef HEADER_STRIPPER_CHECK_EN
        if (force_match) begin
            if (s == 0) exp_in0 = h;
            else        exp_in1 = h[127:0];
        end
        if (((s == 0) ? exp_in0 : {128'b0, exp_in1}) !== h) begin
            exp_mm[s]++;
            return;
        end
`else
        if (force_match) h = h;
`endif
        for (int i = hb; i < pkt.size(); i++)
            exp_q[s].push_back({pkt[i], (i == hb), (i == pkt.size() - 1), (i == pkt.size() - 1) ? emp : 4'd0});
    endtask

    task automatic drive_beat(input int s, input logic [127:0] d, input logic sp, input logic ep, input logic [3:0] emp);
        int t;
        in_data = d; in_sop = sp; in_eop = ep; in_empty = emp;
        if (s == 0) in_valid0 = 1'b1;
        else        in_valid1 = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (i_ready[s] === 1'b1) break;
            t++;
            if (t > 200) begin
                n_checks++; n_fail++;
                $display("FAIL drive_timeout dut%0d ready got 0 want 1", s);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic send_pkt(input int s, input logic [3:0] emp);
        for (int i = 0; i < pkt.size(); i++)
            drive_beat(s, pkt[i], (i == 0), (i == pkt.size() - 1), (i == pkt.size() - 1) ? emp : 4'd0);
    endtask

    task automatic rand_pkt(input int len);
        pkt.delete();
        for (int i = 0; i < len; i++) pkt.push_back({$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_all();
        exp_hdr[0] = '0; exp_hdr[1] = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (o_valid[k] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid dut%0d got %b want 0", k, o_valid[k]); end
            n_checks++; if ({o_data[k], o_sop[k], o_eop[k], o_empty[k]} !== 134'd0) begin n_fail++; $display("FAIL reset_out_fields dut%0d got nonzero want 0", k); end
            n_checks++; if (hdr_w[k] !== 256'd0) begin n_fail++; $display("FAIL reset_header dut%0d got %h want 0", k, hdr_w[k]); end
            n_checks++; if ({o_hv[k], o_se[k]} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses dut%0d got %b want 00", k, {o_hv[k], o_se[k]}); end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        clear_all(); rdy_mode = 0;
        rand_pkt(5);
        model_pkt(0, 4'd5, 1'b1);
        send_pkt(0, 4'd5);
        settle();
        n_checks++; if (obs_q[0].size() != 3) begin n_fail++; $display("FAIL basic_beats got %0d want 3", obs_q[0].size()); end
        for (int i = 0; i < exp_q[0].size() && i < obs_q[0].size(); i++) begin
            n_checks++; if (obs_q[0][i] !== exp_q[0][i]) begin n_fail++; $display("FAIL basic_beat%0d got %h want %h", i, obs_q[0][i], exp_q[0][i]); end
        end
        n_checks++; if (hv[0] !== 1) begin n_fail++; $display("FAIL basic_hv got %0d want 1", hv[0]); end
        n_checks++; if (hdr_seen[0] !== {pkt[0], pkt[1]}) begin n_fail++; $display("FAIL basic_header got %h want %h", hdr_seen[0], {pkt[0], pkt[1]}); end
        n_checks++; if (zero_bad[0] !== 0) begin n_fail++; $display("FAIL basic_idle_zero got %0d want 0", zero_bad[0]); end
    endtask

    task automatic test_backpressure();
        clear_all(); rdy_mode = 1;
        model_pkt(0, 4'd5, 1'b1);
        send_pkt(0, 4'd5);
        settle();
        rdy_mode = 0;
        n_checks++; if (obs_q[0].size() != exp_q[0].size()) begin n_fail++; $display("FAIL bp_beats got %0d want %0d", obs_q[0].size(), exp_q[0].size()); end
        for (int i = 0; i < exp_q[0].size() && i < obs_q[0].size(); i++) begin
            n_checks++; if (obs_q[0][i] !== exp_q[0][i]) begin n_fail++; $display("FAIL bp_beat%0d got %h want %h", i, obs_q[0][i], exp_q[0][i]); end
        end
        n_checks++; if (mirror_bad[0] !== 0) begin n_fail++; $display("FAIL bp_ready_mirror got %0d want 0", mirror_bad[0]); end
        n_checks++; if (hv[0] !== exp_hv[0]) begin n_fail++; $display("FAIL bp_hv got %0d want %0d", hv[0], exp_hv[0]); end
    endtask

    task automatic test_short();
        clear_all(); rdy_mode = 0;
        rand_pkt(1);
        model_pkt(0, 4'd0, 1'b1);
        send_pkt(0, 4'd0);
        settle();
        n_checks++; if (se[0] !== 1) begin n_fail++; $display("FAIL short_err got %0d want 1", se[0]); end
        n_checks++; if (hv[0] !== 0 || obs_q[0].size() != 0) begin n_fail++; $display("FAIL short_no_output got hv=%0d beats=%0d want 0/0", hv[0], obs_q[0].size()); end
        n_checks++; if (hdr_w[0] !== exp_hdr[0]) begin n_fail++; $display("FAIL short_header_kept got %h want %h", hdr_w[0], exp_hdr[0]); end
        clear_all();
        rand_pkt(4);
        model_pkt(0, 4'd9, 1'b1);
        send_pkt(0, 4'd9);
        settle();
        n_checks++; if (obs_q[0].size() != exp_q[0].size()) begin n_fail++; $display("FAIL short_next_beats got %0d want %0d", obs_q[0].size(), exp_q[0].size()); end
        for (int i = 0; i < exp_q[0].size() && i < obs_q[0].size(); i++) begin
            n_checks++; if (obs_q[0][i] !== exp_q[0][i]) begin n_fail++; $display("FAIL short_next_beat%0d got %h want %h", i, obs_q[0][i], exp_q[0][i]); end
        end
        n_checks++; if (hdr_seen[0] !== exp_hdr[0]) begin n_fail++; $display("FAIL short_next_header got %h want %h", hdr_seen[0], exp_hdr[0]); end
    endtask

    task automatic test_single_hdr();
        clear_all(); rdy_mode = 0;
        rand_pkt(2);
        model_pkt(1, 4'd7, 1'b1);
        drive_beat(1, pkt[0], 1'b1, 1'b0, 4'd0);
        drive_beat(1, pkt[1], 1'b1, 1'b1, 4'd7);
        settle();
        n_checks++; if (hv[1] !== 1) begin n_fail++; $display("FAIL single_hv got %0d want 1", hv[1]); end
        n_checks++; if (obs_q[1].size() != 1) begin n_fail++; $display("FAIL single_beats got %0d want 1", obs_q[1].size()); end
        else begin
            n_checks++; if (obs_q[1][0] !== {pkt[1], 1'b1, 1'b1, 4'd7}) begin n_fail++; $display("FAIL single_beat got %h want %h", obs_q[1][0], {pkt[1], 1'b1, 1'b1, 4'd7}); end
        end
        n_checks++; if (hdr_seen[1] !== exp_hdr[1]) begin n_fail++; $display("FAIL single_header got %h want %h", hdr_seen[1], exp_hdr[1]); end
    endtask

    task automatic test_sop_restart();
        logic [127:0] stale;
        clear_all(); rdy_mode = 0;
        stale = {$urandom, $urandom, $urandom, $urandom};
        rand_pkt(3);
        model_pkt(0, 4'd2, 1'b1);
        drive_beat(0, stale,  1'b1, 1'b0, 4'd0);
        drive_beat(0, pkt[0], 1'b1, 1'b0, 4'd0);
        drive_beat(0, pkt[1], 1'b0, 1'b0, 4'd0);
        drive_beat(0, pkt[2], 1'b0, 1'b1, 4'd2);
        settle();
        n_checks++; if (hdr_seen[0] !== {pkt[0], pkt[1]}) begin n_fail++; $display("FAIL restart_header got %h want %h", hdr_seen[0], {pkt[0], pkt[1]}); end
        n_checks++; if (obs_q[0].size() != 1 || obs_q[0][0] !== exp_q[0][0]) begin n_fail++; $display("FAIL restart_payload got %0d beats want 1 matching", obs_q[0].size()); end
    endtask

    task automatic test_mid_reset();
        clear_all(); rdy_mode = 0;
        rand_pkt(4);
        drive_beat(0, pkt[0], 1'b1, 1'b0, 4'd0);
        drive_beat(0, pkt[1], 1'b0, 1'b0, 4'd0);
        drive_beat(0, pkt[2], 1'b0, 1'b0, 4'd0);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if ({o_valid[0], o_sop[0], o_eop[0], o_hv[0], o_se[0]} !== 5'd0) begin n_fail++; $display("FAIL midrst_flags got %b want 00000", {o_valid[0], o_sop[0], o_eop[0], o_hv[0], o_se[0]}); end
        n_checks++; if (hdr_w[0] !== 256'd0) begin n_fail++; $display("FAIL midrst_header got %h want 0", hdr_w[0]); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_all();
        exp_hdr[0] = '0;
        rand_pkt(3);
        model_pkt(0, 4'd1, 1'b1);
        drive_beat(0, pkt[0], 1'b0, 1'b0, 4'd0);
        drive_beat(0, pkt[1], 1'b0, 1'b0, 4'd0);
        drive_beat(0, pkt[2], 1'b0, 1'b1, 4'd1);
        settle();
        n_checks++; if (hdr_seen[0] !== exp_hdr[0] || hv[0] !== 1) begin n_fail++; $display("FAIL midrst_reparse got %h/%0d want %h/1", hdr_seen[0], hv[0], exp_hdr[0]); end
        n_checks++; if (obs_q[0].size() != 1 || obs_q[0][0] !== exp_q[0][0]) begin n_fail++; $display("FAIL midrst_payload got %0d beats want 1 matching", obs_q[0].size()); end
    endtask

    task automatic test_random();
        int         s, len;
        logic [3:0] emp;
        clear_all(); rdy_mode = 2;
        for (int n = 0; n < 24; n++) begin
            s   = $urandom_range(0, 1);
            len = $urandom_range(1, 5);
            emp = 4'($urandom_range(0, 15));
            rand_pkt(len);
            model_pkt(s, emp, ($urandom_range(0, 3) != 0));
            send_pkt(s, emp);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        settle();
        rdy_mode = 0;
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (obs_q[k].size() != exp_q[k].size()) begin n_fail++; $display("FAIL rand_beats dut%0d got %0d want %0d", k, obs_q[k].size(), exp_q[k].size()); end
            for (int i = 0; i < exp_q[k].size() && i < obs_q[k].size(); i++) begin
                n_checks++; if (obs_q[k][i] !== exp_q[k][i]) begin n_fail++; $display("FAIL rand_beat dut%0d #%0d got %h want %h", k, i, obs_q[k][i], exp_q[k][i]); end
            end
            n_checks++; if (hv[k] !== exp_hv[k]) begin n_fail++; $display("FAIL rand_hv dut%0d got %0d want %0d", k, hv[k], exp_hv[k]); end
            n_checks++; if (se[k] !== exp_se[k]) begin n_fail++; $display("FAIL rand_short dut%0d got %0d want %0d", k, se[k], exp_se[k]); end
            n_checks++; if (mm[k] !== exp_mm[k]) begin n_fail++; $display("FAIL rand_mismatch dut%0d got %0d want %0d", k, mm[k], exp_mm[k]); end
            n_checks++; if (mirror_bad[k] !== 0 || zero_bad[k] !== 0) begin n_fail++; $display("FAIL rand_handshake dut%0d got %0d/%0d want 0/0", k, mirror_bad[k], zero_bad[k]); end
            if (exp_hv[k] > 0) begin
                n_checks++; if (hdr_seen[k] !== exp_hdr[k]) begin n_fail++; $display("FAIL rand_header dut%0d got %h want %h", k, hdr_seen[k], exp_hdr[k]); end
            end
        end
    endtask

`ifdef HEADER_STRIPPER_CHECK_EN
    task automatic test_check_en();
        clear_all(); rdy_mode = 3;
        exp_in0 = {32{8'hA5}};
        pkt.delete();
        pkt.push_back({16{8'h5A}}); pkt.push_back({16{8'h5A}});
        pkt.push_back({$urandom, $urandom, $urandom, $urandom});
        pkt.push_back({$urandom, $urandom, $urandom, $urandom});
        model_pkt(0, 4'd3, 1'b0);
        send_pkt(0, 4'd3);
        settle();
        n_checks++; if (mm[0] !== 1 || exp_mm[0] !== 1) begin n_fail++; $display("FAIL chk_mismatch got %0d want 1", mm[0]); end
        n_checks++; if (hv[0] !== 1) begin n_fail++; $display("FAIL chk_hv got %0d want 1", hv[0]); end
        n_checks++; if (obs_q[0].size() != 0 || zero_bad[0] !== 0) begin n_fail++; $display("FAIL chk_dropped got %0d beats want 0", obs_q[0].size()); end
        clear_all(); rdy_mode = 0;
        rand_pkt(3);
        model_pkt(0, 4'd4, 1'b1);
        send_pkt(0, 4'd4);
        settle();
        n_checks++; if (mm[0] !== 0 || obs_q[0].size() != 1 || obs_q[0][0] !== exp_q[0][0]) begin n_fail++; $display("FAIL chk_match got mm=%0d beats=%0d want 0/1", mm[0], obs_q[0].size()); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_short();
        test_single_hdr();
        test_sop_restart();
        test_mid_reset();
        test_random();
`ifdef HEADER_STRIPPER_CHECK_EN
        test_check_en();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
